// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the vector datapath (Q16.16 lanes packed
// three to a vector) and the lane sequencer states of the serial vector blocks.
package fixed_pkg;

  localparam int FIXED_W   = 32;
  localparam int FRAC_BITS = 16;

  localparam logic [FIXED_W-1:0] FIXED_MAX = 32'h7FFF_FFFF;
  localparam logic [FIXED_W-1:0] FIXED_MIN = 32'h8000_0000;

  localparam int VEC_LANES = 3;
  localparam int VEC_W     = FIXED_W * VEC_LANES;

  // One state per lane: the shared adder serves lane k while in LANEk.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE0 = 2'd1,
    LANE1 = 2'd2,
    LANE2 = 2'd3
  } vec_state_e;

endpackage

// File: rtl/fixed_add_sat_comb.sv
// Combinational two's-complement adder with overflow flag and optional
// clamp-to-range; shared by the serial vector blocks.
module fixed_add_sat_comb
  import fixed_pkg::*;
#(
  parameter int WIDTH    = FIXED_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sat_val;

  assign sum_ext = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};

  // The extra bit holds the true sign; disagreement with bit WIDTH-1 means the
  // result no longer fits, which only happens when the operand signs match.
  assign ovf_o = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];

  assign sat_val = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};

  assign sum_o = (SATURATE && ovf_o) ? sat_val : sum_ext[WIDTH-1:0];

endmodule

// File: rtl/vector_add_seq.sv
// Component-serial vector adder r = v1 + v2: one shared adder walks x, y, z on
// consecutive cycles, with a busy/accept handshake and a one-cycle output_valid.
module vector_add_seq
  import fixed_pkg::*;
#(
  parameter int WIDTH    = FIXED_W,
  parameter int LANES    = VEC_LANES,
  parameter bit SATURATE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_data,
  output logic                   busy,
  output logic                   output_valid,
  input  logic [WIDTH*LANES-1:0] v1,
  input  logic [WIDTH*LANES-1:0] v2,
  output logic [WIDTH*LANES-1:0] r,
  output logic [LANES-1:0]       overflow
);

  vec_state_e             state_q;
  logic [WIDTH*LANES-1:0] v1_q;
  logic [WIDTH*LANES-1:0] v2_q;
  logic [WIDTH*LANES-1:0] r_q;
  logic [LANES-1:0]       overflow_q;
  logic                   output_valid_q;

  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_ovf;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      LANE0: begin
        op_a = v1_q[0*WIDTH +: WIDTH];
        op_b = v2_q[0*WIDTH +: WIDTH];
      end
      LANE1: begin
        op_a = v1_q[1*WIDTH +: WIDTH];
        op_b = v2_q[1*WIDTH +: WIDTH];
      end
      LANE2: begin
        op_a = v1_q[2*WIDTH +: WIDTH];
        op_b = v2_q[2*WIDTH +: WIDTH];
      end
      default: ;
    endcase
  end

  fixed_add_sat_comb #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a_i   (op_a),
    .b_i   (op_b),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the operand registers are reset too, so a stale vector can never
  // leak into a result after an aborted operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      v1_q           <= '0;
      v2_q           <= '0;
      r_q            <= '0;
      overflow_q     <= '0;
      output_valid_q <= 1'b0;
    end else begin
      output_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (new_data) begin
            v1_q    <= v1;
            v2_q    <= v2;
            state_q <= LANE0;
          end
        end
        LANE0: begin
          r_q[0*WIDTH +: WIDTH] <= add_sum;
          overflow_q[0]         <= add_ovf;
          state_q               <= LANE1;
        end
        LANE1: begin
          r_q[1*WIDTH +: WIDTH] <= add_sum;
          overflow_q[1]         <= add_ovf;
          state_q               <= LANE2;
        end
        LANE2: begin
          r_q[2*WIDTH +: WIDTH] <= add_sum;
          overflow_q[2]         <= add_ovf;
          output_valid_q        <= 1'b1;
          state_q               <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign output_valid = output_valid_q;
  assign r            = r_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_vector_add_seq.sv
// Bench for vector_add_seq: saturating and wrapping instances share stimulus;
// expected sums are queued at accept and compared as results appear.
module tb_vector_add_seq;
  import fixed_pkg::*;

  localparam int W  = FIXED_W;
  localparam int L  = VEC_LANES;
  localparam int VW = VEC_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          new_data = 1'b0;
  logic [VW-1:0] v1 = '0;
  logic [VW-1:0] v2 = '0;
  logic          busy_s, valid_s, busy_w, valid_w;
  logic [VW-1:0] r_s, r_w;
  logic [L-1:0]  ovf_s, ovf_w;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vector_add_seq #(.WIDTH(W), .LANES(L), .SATURATE(1'b1)) dut_sat (
    .clk (clk), .rst (rst), .new_data (new_data), .busy (busy_s),
    .output_valid (valid_s), .v1 (v1), .v2 (v2), .r (r_s), .overflow (ovf_s)
  );

  vector_add_seq #(.WIDTH(W), .LANES(L), .SATURATE(1'b0)) dut_wrap (
    .clk (clk), .rst (rst), .new_data (new_data), .busy (busy_w),
    .output_valid (valid_w), .v1 (v1), .v2 (v2), .r (r_w), .overflow (ovf_w)
  );

  typedef struct {
    logic [VW-1:0] r_sat;
    logic [L-1:0]  ovf;
    logic [VW-1:0] r_wrap;
  } exp_t;

  typedef struct {
    logic [VW-1:0] r_sat;
    logic [VW-1:0] r_wrap;
    logic [L-1:0]  ovf_sat;
    logic [L-1:0]  ovf_wrap;
    logic          valid_wrap;
    int            cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   tests_run = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    exp_t         e;
    logic [W-1:0] x, y;
    logic [W:0]   s;
    for (int k = 0; k < L; k++) begin
      x = a[k*W +: W];
      y = b[k*W +: W];
      s = {x[W-1], x} + {y[W-1], y};
      e.ovf[k]           = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      e.r_wrap[k*W +: W] = s[W-1:0];
      e.r_sat[k*W +: W]  = !e.ovf[k] ? s[W-1:0] : (x[W-1] ? FIXED_MIN : FIXED_MAX);
    end
    return e;
  endfunction

  // One cycle forward, sampling half a period away from the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
    if (valid_s)
      obs_q.push_back('{r_sat: r_s, r_wrap: r_w, ovf_sat: ovf_s, ovf_wrap: ovf_w,
                        valid_wrap: valid_w, cyc: cyc});
  endtask

  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, output int acc);
    v1 = a;
    v2 = b;
    new_data = 1'b1;
    step();
    acc = cyc;
    new_data = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 20 && obs_q.size() < n; i++) step();
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    step();
    tests_run += 4;
    if ({busy_s, busy_w} !== 2'b00) begin
      fails++; $display("FAIL reset_busy got=%b want=00", {busy_s, busy_w});
    end
    if ({valid_s, valid_w} !== 2'b00) begin
      fails++; $display("FAIL reset_valid got=%b want=00", {valid_s, valid_w});
    end
    if ({r_s, r_w} !== '0) begin
      fails++; $display("FAIL reset_r got=%h/%h want=0", r_s, r_w);
    end
    if ({ovf_s, ovf_w} !== '0) begin
      fails++; $display("FAIL reset_ovf got=%b/%b want=0", ovf_s, ovf_w);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int   acc;
    obs_t o;
    exp_t e;
    send({32'hFFFD0000, 32'h00020000, 32'h00010000},
         {32'h00010000, 32'hFFFE0000, 32'h00008000}, acc);
    exp_q.push_back('{r_sat:  {32'hFFFE0000, 32'h00000000, 32'h00018000}, ovf: 3'b000,
                      r_wrap: {32'hFFFE0000, 32'h00000000, 32'h00018000}});
    tests_run++;
    if (busy_s !== 1'b1) begin
      fails++; $display("FAIL basic_busy got=%b want=1", busy_s);
    end
    wait_results(1);
    tests_run += 2;
    if (obs_q.size() == 0) begin
      fails += 2; $display("FAIL basic_timeout got=no output_valid want=one result");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if ({o.r_sat, o.ovf_sat, o.r_wrap, o.ovf_wrap, o.valid_wrap} !== {e.r_sat, e.ovf, e.r_wrap, e.ovf, 1'b1}) begin
        fails++; $display("FAIL basic_sum got=%h/%b %h/%b want=%h/%b %h", o.r_sat, o.ovf_sat, o.r_wrap, o.ovf_wrap, e.r_sat, e.ovf, e.r_wrap);
      end
      if (o.cyc - acc !== 3) begin
        fails++; $display("FAIL basic_latency got=%0d want=3", o.cyc - acc);
      end
    end
  endtask

  task automatic test_saturation();
    int   acc;
    obs_t o;
    exp_t e;
    send({32'h00000001, 32'h80000000, 32'h7FFF0000},
         {32'h00000002, 32'hFFFFFFFF, 32'h00020000}, acc);
    exp_q.push_back('{r_sat:  {32'h00000003, 32'h80000000, 32'h7FFFFFFF}, ovf: 3'b011,
                      r_wrap: {32'h00000003, 32'h7FFFFFFF, 32'h80010000}});
    wait_results(1);
    tests_run += 2;
    if (obs_q.size() == 0) begin
      fails += 2; $display("FAIL sat_timeout got=no output_valid want=one result");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if ({o.r_sat, o.ovf_sat, o.valid_wrap} !== {e.r_sat, e.ovf, 1'b1}) begin
        fails++; $display("FAIL sat_clamp got=%h/%b want=%h/%b", o.r_sat, o.ovf_sat, e.r_sat, e.ovf);
      end
      if ({o.r_wrap, o.ovf_wrap} !== {e.r_wrap, e.ovf}) begin
        fails++; $display("FAIL sat_wrap got=%h/%b want=%h/%b", o.r_wrap, o.ovf_wrap, e.r_wrap, e.ovf);
      end
    end
  endtask

  task automatic test_busy_drop();
    int            acc, busy_cnt;
    logic [VW-1:0] a, b;
    obs_t          o;
    exp_t          e;
    a = rnd_vec();
    b = rnd_vec();
    send(a, b, acc);
    exp_q.push_back(model(a, b));
    busy_cnt = busy_s ? 1 : 0;
    v1 = rnd_vec();
    v2 = rnd_vec();
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    if (busy_s) busy_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy_s) busy_cnt++;
    end
    tests_run += 3;
    if (busy_cnt !== 3) begin
      fails++; $display("FAIL drop_busy_cycles got=%0d want=3", busy_cnt);
    end
    if (obs_q.size() !== 1) begin
      fails++; $display("FAIL drop_valid_count got=%0d want=1", obs_q.size());
    end
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL drop_sum got=no output_valid want=first operands' sum");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if ({o.r_sat, o.ovf_sat, o.r_wrap, o.ovf_wrap} !== {e.r_sat, e.ovf, e.r_wrap, e.ovf}) begin
        fails++; $display("FAIL drop_sum got=%h/%b %h want=%h/%b %h", o.r_sat, o.ovf_sat, o.r_wrap, e.r_sat, e.ovf, e.r_wrap);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_isolation();
    int            acc;
    logic [VW-1:0] a, b;
    obs_t          o;
    exp_t          e;
    a = {32'h12345678, 32'hC0000000, 32'h7FFFFFFF};
    b = {32'h0000FFFF, 32'hC0000000, 32'h00000001};
    send(a, b, acc);
    exp_q.push_back(model(a, b));
    for (int i = 0; i < 3; i++) begin
      v1 = rnd_vec();
      v2 = rnd_vec();
      step();
    end
    wait_results(1);
    tests_run++;
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL iso_timeout got=no output_valid want=one result");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if ({o.r_sat, o.ovf_sat, o.r_wrap, o.ovf_wrap} !== {e.r_sat, e.ovf, e.r_wrap, e.ovf}) begin
        fails++; $display("FAIL iso_sum got=%h/%b %h want=%h/%b %h", o.r_sat, o.ovf_sat, o.r_wrap, e.r_sat, e.ovf, e.r_wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    int            acc;
    logic [VW-1:0] a, b;
    obs_t          o1, o2;
    exp_t          e1, e2;
    a = rnd_vec();
    b = rnd_vec();
    send(a, b, acc);
    exp_q.push_back(model(a, b));
    for (int i = 0; i < 10 && !valid_s; i++) step();
    a = rnd_vec();
    b = rnd_vec();
    v1 = a;
    v2 = b;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    exp_q.push_back(model(a, b));
    wait_results(2);
    tests_run += 3;
    if (obs_q.size() < 2) begin
      fails += 3; $display("FAIL b2b_timeout got=%0d results want=2", obs_q.size());
      obs_q.delete();
      exp_q.delete();
    end else begin
      o1 = obs_q.pop_front();
      o2 = obs_q.pop_front();
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      if ({o1.r_sat, o1.ovf_sat, o1.r_wrap} !== {e1.r_sat, e1.ovf, e1.r_wrap}) begin
        fails++; $display("FAIL b2b_first got=%h/%b %h want=%h/%b %h", o1.r_sat, o1.ovf_sat, o1.r_wrap, e1.r_sat, e1.ovf, e1.r_wrap);
      end
      if ({o2.r_sat, o2.ovf_sat, o2.r_wrap} !== {e2.r_sat, e2.ovf, e2.r_wrap}) begin
        fails++; $display("FAIL b2b_second got=%h/%b %h want=%h/%b %h", o2.r_sat, o2.ovf_sat, o2.r_wrap, e2.r_sat, e2.ovf, e2.r_wrap);
      end
      if (o2.cyc - o1.cyc !== 4) begin
        fails++; $display("FAIL b2b_spacing got=%0d want=4", o2.cyc - o1.cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int            acc;
    logic [VW-1:0] a, b;
    obs_t          o;
    exp_t          e;
    send({32'h00030000, 32'h00020000, 32'h00010000},
         {32'h00030000, 32'h00020000, 32'h00010000}, acc);
    step();
    rst = 1'b0;
    #1;
    tests_run += 2;
    if ({busy_s, valid_s, busy_w, valid_w} !== 4'b0000) begin
      fails++; $display("FAIL midrst_ctrl got=%b want=0000", {busy_s, valid_s, busy_w, valid_w});
    end
    if ({r_s, ovf_s, r_w, ovf_w} !== '0) begin
      fails++; $display("FAIL midrst_data got=%h/%b %h/%b want=0", r_s, ovf_s, r_w, ovf_w);
    end
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tests_run++;
    if (obs_q.size() !== 0) begin
      fails++; $display("FAIL midrst_ghost_valid got=%0d want=0", obs_q.size());
    end
    obs_q.delete();
    a = rnd_vec();
    b = rnd_vec();
    send(a, b, acc);
    exp_q.push_back(model(a, b));
    wait_results(1);
    tests_run++;
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL midrst_after got=no output_valid want=one result");
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if ({o.r_sat, o.ovf_sat, o.r_wrap, o.ovf_wrap} !== {e.r_sat, e.ovf, e.r_wrap, e.ovf}) begin
        fails++; $display("FAIL midrst_after got=%h/%b %h want=%h/%b %h", o.r_sat, o.ovf_sat, o.r_wrap, e.r_sat, e.ovf, e.r_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_busy_drop();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
      fails++; $display("FAIL leftover got=%0d expected/%0d observed want=0/0", exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vector_add_seq.md
Name: vector_add_seq

Overview:
- Component-serial 3-lane fixed-point vector adder (r = v1 + v2); the inverse operation of the team's vector subtractor.
- Used in the raytracer to rebuild points from a differenced vector, e.g. hit point = origin + scaled direction.
- One shared 32-bit adder is time-multiplexed across x/y/z to save DSP/LUT area, so the block has its own accept/busy handshake.
- Consumes the same new_data/output_valid pulse protocol as the rest of the vector datapath.

Parameters:
- WIDTH, 32, bits per lane; two's-complement fixed point.
- LANES, 3, vector components; lane i occupies bits [WIDTH*i +: WIDTH].
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- new_data  input  1  one-cycle pulse; v1/v2 are valid this cycle.
- busy  output  1  high while an operation is in flight; new_data is ignored while high.
- output_valid  output  1  one-cycle pulse; r and overflow are valid.
- v1  input  WIDTH*LANES  first operand.
- v2  input  WIDTH*LANES  second operand.
- r  output  WIDTH*LANES  sum, registered.
- overflow  output  LANES  per-lane overflow flag, registered, valid with output_valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0; output_valid=0; r=0; overflow=0; operand registers=0.
- FSM states: IDLE, LANE0, LANE1, LANE2.
  - IDLE & new_data: latch v1 and v2 into operand registers, go to LANE0.
  - IDLE & !new_data: stay in IDLE.
  - LANE0 -> LANE1 -> LANE2 -> IDLE, unconditionally, one clock each.
- In LANEk: r[k] and overflow[k] are written from the shared adder fed by operand lane k. Other lanes of r hold their values.
- busy = (state != IDLE), driven combinationally from the state register.
- output_valid is registered: 1 for exactly the cycle after the LANE2 edge, i.e. the first cycle back in IDLE.
- Latency: new_data sampled at edge E0 -> output_valid high in the cycle following edge E3 (3 cycles).
- Throughput: new_data may be asserted in the same cycle output_valid is high and is accepted, giving one vector per 4 cycles maximum.
- new_data while busy=1 is dropped silently. Operands, state and r are unaffected.
- r holds the last result until lanes are overwritten by the next operation. r is partially updated during LANE0..LANE2; consumers sample r only on output_valid.
- Arithmetic:
  - Compute a WIDTH+1-bit signed sum.
  - Overflow when both operand sign bits are equal and the result sign bit differs.
  - SATURATE=1: a positive overflow gives 0x7FFFFFFF; a negative overflow gives 0x80000000.
  - SATURATE=0: result is the low WIDTH bits.
  - overflow[k] is set in both modes.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values and no output_valid is produced. After reset releases, the first new_data is accepted normally.
- Inputs v1/v2 may change freely after the accept edge; only the latched copies are used.

Decomposition:
- Shared package (fixed_pkg):
  - FIXED_W=32, FRAC_BITS=16 (Q16.16), FIXED_MAX=32'h7FFFFFFF, FIXED_MIN=32'h80000000.
  - Lane-slice helper constant VEC_W=96.
- Sub-module fixed_add_sat_comb: combinational a+b -> {r, ovf}, with SATURATE parameter. Instanced once as the shared adder; reusable elsewhere.

Test Plan:
- Basic add: v1=(1.0,2.0,-3.0)={0x00010000,0x00020000,0xFFFD0000}, v2=(0.5,-2.0,1.0) -> output_valid 3 cycles after accept; r={0x00018000,0x00000000,0xFFFE0000}; overflow=000.
- Saturation: SATURATE=1, lane0 0x7FFF0000+0x00020000 -> r[0]=0x7FFFFFFF; lane1 0x80000000+0xFFFFFFFF -> r[1]=0x80000000; overflow=011. With SATURATE=0 the same inputs give r[0]=0x80010000 and r[1]=0x7FFFFFFF.
- Busy drop: second new_data pulse one cycle after accept with different operands -> ignored; only one output_valid, carrying the first operands' sum; busy=1 for exactly 3 cycles.
- Back-to-back: new_data asserted in the output_valid cycle -> accepted; next output_valid exactly 4 cycles after the previous one.
- Reset mid-op: rst=0 during LANE1 -> busy, output_valid, r and overflow go to 0 immediately (asynchronously); no output_valid after release. A new request then completes with the correct sum.
- Operand isolation: v1/v2 driven with garbage from the cycle after accept -> r still equals the sum of the latched operands.
